// File: rtl/d1_predecode_queue.sv
// d1_predecode_queue: 4-entry fetch-to-decode FIFO that predecodes format,
// uop count and legality as each instruction is written.
module d1_predecode_queue (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        f_valid,
   output logic        f_ready,
   input  logic [31:0] f_pc,
   input  logic [31:0] f_instr,
   input  logic        f_exception,
   output logic        d2_valid,
   input  logic        d2_ready,
   output logic [31:0] pc_out,
   output logic [31:0] instruction_out,
   output logic [4:0]  opcode_format,
   output logic [1:0]  uop_count,
   output logic        exception_out,
   output logic [2:0]  occupancy
);
   logic [31:0] r_pc    [4];
   logic [31:0] r_instr [4];
   logic [4:0]  r_fmt   [4];
   logic [1:0]  r_uop   [4];
   logic        r_exc   [4];
   logic        r_ill   [4];
   logic [1:0]  r_wr, r_rd;
   logic [2:0]  r_count;
   logic        w_push, w_pop, w_legal;
   logic [4:0]  w_fmt;
   logic [1:0]  w_uop;

   assign f_ready   = r_count != 3'd4;
   assign d2_valid  = r_count != 3'd0;
   assign occupancy = r_count;
   assign w_push    = f_valid && f_ready && !flush;
   assign w_pop     = d2_valid && d2_ready && !flush;

   assign w_fmt   = f_instr[6:2];
   assign w_legal = f_instr[1:0] == 2'b11 && (w_fmt inside {5'b00000, 5'b00011, 5'b00100, 5'b00101,
                                                            5'b01000, 5'b01011, 5'b01100, 5'b01101,
                                                            5'b11000, 5'b11001, 5'b11011, 5'b11100});
   assign w_uop   = !w_legal ? 2'd1 :
                    w_fmt == 5'b01011 ? 2'd3 :
                    (w_fmt == 5'b11011 || w_fmt == 5'b11001) ? 2'd2 : 2'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr    <= 2'd0;
         r_rd    <= 2'd0;
         r_count <= 3'd0;
      end else if (flush) begin
         r_wr    <= 2'd0;
         r_rd    <= 2'd0;
         r_count <= 3'd0;
      end else begin
         if (w_push) r_wr <= r_wr + 2'd1;
         if (w_pop) r_rd <= r_rd + 2'd1;
         r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
      end
   end

   // payload is never reset; r_count alone decides what is visible
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc[r_wr]    <= f_pc;
         r_instr[r_wr] <= f_instr;
         r_fmt[r_wr]   <= w_fmt;
         r_uop[r_wr]   <= w_uop;
         r_exc[r_wr]   <= f_exception;
         r_ill[r_wr]   <= !w_legal;
      end
   end

   assign pc_out          = d2_valid ? r_pc[r_rd] : 32'd0;
   assign instruction_out = d2_valid ? r_instr[r_rd] : 32'd0;
   assign opcode_format   = d2_valid ? r_fmt[r_rd] : 5'd0;
   assign uop_count       = d2_valid ? r_uop[r_rd] : 2'd0;
   assign exception_out   = d2_valid && (r_exc[r_rd] || r_ill[r_rd]);
endmodule

// File: tb/tb_d1_predecode_queue.sv
// tb_d1_predecode_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the predecode FIFO.
module tb_d1_predecode_queue;
   logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, f_valid = 1'b0, f_exception = 1'b0, d2_ready = 1'b0;
   logic [31:0] f_pc = '0, f_instr = '0;
   logic        f_ready, d2_valid, exception_out;
   logic [31:0] pc_out, instruction_out;
   logic [4:0]  opcode_format;
   logic [1:0]  uop_count;
   logic [2:0]  occupancy;
   int          total = 0, bad = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
   } ent_t;
   ent_t model[$];

   d1_predecode_queue dut (
      .clk(clk), .rst(rst), .flush(flush), .f_valid(f_valid), .f_ready(f_ready),
      .f_pc(f_pc), .f_instr(f_instr), .f_exception(f_exception),
      .d2_valid(d2_valid), .d2_ready(d2_ready), .pc_out(pc_out),
      .instruction_out(instruction_out), .opcode_format(opcode_format),
      .uop_count(uop_count), .exception_out(exception_out), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   wire [76:0] observed = {d2_valid, f_ready, occupancy, pc_out, instruction_out,
                           opcode_format, uop_count, exception_out};

   function automatic logic legal(input logic [31:0] i);
      logic [4:0] ops [12] = '{5'h00, 5'h03, 5'h04, 5'h05, 5'h08, 5'h0B,
                               5'h0C, 5'h0D, 5'h18, 5'h19, 5'h1B, 5'h1C};
      legal = 1'b0;
      if (i[1:0] == 2'b11)
         foreach (ops[k]) if (ops[k] == i[6:2]) legal = 1'b1;
   endfunction

   function automatic logic [1:0] uops(input logic [31:0] i);
      if (!legal(i)) return 2'd1;
      if (i[6:2] == 5'h0B) return 2'd3;
      if (i[6:2] == 5'h1B || i[6:2] == 5'h19) return 2'd2;
      return 2'd1;
   endfunction

   function automatic logic [76:0] expected();
      ent_t h;
      if (model.size() == 0) return {1'b0, 1'b1, 75'd0};
      h = model[0];
      return {1'b1, model.size() != 4, 3'(model.size()), h.pc, h.instr, h.instr[6:2],
              uops(h.instr), h.exc || !legal(h.instr)};
   endfunction

   // one clock: apply inputs, advance the model by the queue rules, sample after the edge
   task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                        input logic fe, input logic dr, input logic fl);
      logic push, pop;
      f_valid = fv; f_pc = pc; f_instr = instr; f_exception = fe; d2_ready = dr; flush = fl;
      push = fv && model.size() < 4 && !fl;
      pop  = dr && model.size() > 0 && !fl;
      @(posedge clk);
      #1;
      if (fl) model.delete();
      else begin
         if (pop) void'(model.pop_front());
         if (push) model.push_back('{pc, instr, fe});
      end
      f_valid = 1'b0; flush = 1'b0; d2_ready = 1'b0; f_exception = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      total++;
      if (observed !== {1'b0, 1'b1, 75'd0}) begin
         bad++; $display("FAIL reset_state got %h want %h", observed, {1'b0, 1'b1, 75'd0});
      end
      rst = 1'b1;
   endtask

   task automatic test_single_push();
      drive(1'b1, 32'h100, 32'h00A00093, 1'b0, 1'b1, 1'b0);
      total++;
      if ({d2_valid, pc_out, opcode_format, uop_count, exception_out} !== {1'b1, 32'h100, 5'b00100, 2'd1, 1'b0}) begin
         bad++; $display("FAIL single_push got v=%b pc=%h fmt=%b uop=%0d exc=%b want v=1 pc=100 fmt=00100 uop=1 exc=0",
                         d2_valid, pc_out, opcode_format, uop_count, exception_out);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      total++;
      if (d2_valid !== 1'b0 || pc_out !== 32'h0) begin
         bad++; $display("FAIL single_pop got v=%b pc=%h want v=0 pc=0", d2_valid, pc_out);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) drive(1'b1, 32'(4 * i), 32'h00A00093, 1'b0, 1'b0, 1'b0);
      total++;
      if (f_ready !== 1'b0 || occupancy !== 3'd4) begin
         bad++; $display("FAIL fill_full got rdy=%b occ=%0d want rdy=0 occ=4", f_ready, occupancy);
      end
      drive(1'b1, 32'h10, 32'h00A00093, 1'b0, 1'b0, 1'b0);
      total++;
      if (occupancy !== 3'd4 || pc_out !== 32'h0) begin
         bad++; $display("FAIL fill_fifth got occ=%0d pc=%h want occ=4 pc=0", occupancy, pc_out);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (pc_out !== 32'(4 * i)) begin
            bad++; $display("FAIL drain_order got %h want %h", pc_out, 32'(4 * i));
         end
         drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      end
      total++;
      if (d2_valid !== 1'b0) begin
         bad++; $display("FAIL drain_empty got v=%b want v=0", d2_valid);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 32'h200, 32'h00A00093, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h204, 32'h00A00093, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         total++;
         if (pc_out !== 32'h200 + 32'(4 * k)) begin
            bad++; $display("FAIL pushpop_head got %h want %h", pc_out, 32'h200 + 32'(4 * k));
         end
         drive(1'b1, 32'h208 + 32'(4 * k), 32'h00A00093, 1'b0, 1'b1, 1'b0);
         total++;
         if (occupancy !== 3'd2) begin
            bad++; $display("FAIL pushpop_occ got %0d want 2", occupancy);
         end
      end
      for (int i = 0; i < 2; i++) begin
         total++;
         if (pc_out !== 32'h20C + 32'(4 * i)) begin
            bad++; $display("FAIL pushpop_tail got %h want %h", pc_out, 32'h20C + 32'(4 * i));
         end
         drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_predecode();
      logic [31:0] vi [5] = '{32'h0000006F, 32'h0C52A2AF, 32'h00000000, 32'hFFFFFFFF, 32'h00A00093};
      logic        vf [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [1:0]  vu [5] = '{2'd2, 2'd3, 2'd1, 2'd1, 2'd1};
      logic        ve [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h300, vi[i], vf[i], 1'b0, 1'b0);
         total++;
         if (uop_count !== vu[i] || exception_out !== ve[i] || opcode_format !== vi[i][6:2]) begin
            bad++; $display("FAIL predecode %h got uop=%0d exc=%b fmt=%b want uop=%0d exc=%b fmt=%b",
                            vi[i], uop_count, exception_out, opcode_format, vu[i], ve[i], vi[i][6:2]);
         end
         drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) drive(1'b1, 32'h400 + 32'(4 * i), 32'h00A00093, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h999, 32'h00A00093, 1'b0, 1'b1, 1'b1);
      total++;
      if ({occupancy, d2_valid, f_ready} !== {3'd0, 1'b0, 1'b1}) begin
         bad++; $display("FAIL flush got occ=%0d v=%b rdy=%b want occ=0 v=0 rdy=1", occupancy, d2_valid, f_ready);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h500, 32'h00A00093, 1'b0, 1'b0, 1'b0);
      total++;
      if (pc_out !== 32'h500 || occupancy !== 3'd1) begin
         bad++; $display("FAIL flush_dropped got pc=%h occ=%0d want pc=500 occ=1", pc_out, occupancy);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_async_reset();
      drive(1'b1, 32'h600, 32'h00A00093, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h604, 32'h00A00093, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      total++;
      if (observed !== {1'b0, 1'b1, 75'd0}) begin
         bad++; $display("FAIL async_reset got %h want %h", observed, {1'b0, 1'b1, 75'd0});
      end
      model.delete();
      #1 rst = 1'b1;
      test_single_push();
   endtask

   task automatic test_random();
      logic [4:0]  sp [4] = '{5'h0B, 5'h1B, 5'h19, 5'h04};
      logic [31:0] instr;
      logic        dr;
      for (int n = 0; n < 400; n++) begin
         instr = $urandom;
         if ($urandom_range(0, 3) != 0) instr[1:0] = 2'b11;
         if ($urandom_range(0, 2) == 0) instr[6:2] = sp[$urandom_range(0, 3)];
         dr = (n % 80 < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         drive($urandom_range(0, 3) != 0, $urandom, instr, $urandom_range(0, 7) == 0, dr,
               $urandom_range(0, 29) == 0);
         total++;
         if (observed !== expected()) begin
            bad++; $display("FAIL random[%0d] got %h want %h", n, observed, expected());
         end
      end
   endtask

   initial begin
      test_reset();
      @(posedge clk);
      #1;
      test_single_push();
      test_fill();
      test_back_to_back();
      test_predecode();
      test_flush();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
